alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Registered ALU-control/issue stage between instruction decode and the execute-stage ALU cluster. Decodes ALUOp and the R-type funct field into the execute cluster's control bundle (operation, SignaltoMULTU, SignaltoSHT, SignaltoMUX). It tracks the multi-cycle MULTU in flight and stalls MULTU/MFHI/MFLO until the Hi/Lo result is final. One-cycle issue latency; acts as the control half of the ID/EX register.

## Interface
- MULT_CYCLES, 32, cycles from MULTU issue until Hi/Lo are valid (≥1)
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  decoded instruction present
- ALUOp  input  2  00 add (lw/sw), 01 sub (beq), 10 R-type (use funct), 11 slt (slti)
- funct  input  6  R-type function field
- flush  input  1  kill the incoming instruction (branch/jump redirect)
- stall  output  1  combinational; upstream holds instruction when high
- ex_valid  output  1  registered; execute-stage control is a real instruction
- operation  output  3  ALU op: AND 000, OR 001, ADD 010, SUB 110, SLT 111
- SignaltoMULTU  output  1  one-cycle start pulse to the multiplier
- SignaltoSHT  output  1  shifter select (SLL)
- SignaltoMUX  output  2  result select: 00 ALU, 01 Hi, 10 Lo, 11 shifter
- jr  output  1  registered; issued instruction is JR
- illegal  output  1  registered one-cycle pulse on an undecodable R-type funct

## Operation
- Decode for ALUOp=10: funct 36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT (MUX 00). Funct 0 SLL (SHT 1, MUX 11). Funct 25 MULTU (MULTU pulse, MUX 00). Funct 16 MFHI (MUX 01). Funct 18 MFLO (MUX 10). Funct 8 JR (jr 1, op ADD, MUX 00).
- ALUOp 00/01/11 ignore funct: op ADD/SUB/SLT, MUX 00.
- Bubble bundle: ex_valid 0, operation 010, SignaltoMULTU 0, SignaltoSHT 0, SignaltoMUX 00, jr 0.
- Busy counter cnt, width $clog2(MULT_CYCLES+1). busy = (cnt != 0).
- is_hilo = ALUOp==10 and funct in {25,16,18}.
- stall = in_valid & busy & is_hilo. Never depends on flush.
- accept = in_valid & ~stall & ~flush.
- On accept of a legal op: register the decoded bundle with ex_valid 1. Otherwise register the bubble.
- On accept of an illegal funct: register the bubble, illegal 1 for one cycle.
- On accept of MULTU: cnt <= MULT_CYCLES. Else if busy: cnt <= cnt-1. Flushed MULTU does not load cnt.
- Flush does not cancel an in-flight multiply; cnt keeps counting.
- Back-to-back MULTU stalls until the previous one completes.
- Non-Hi/Lo instructions issue freely while busy.

## Timing
- Reset (rst=0 at an edge): cnt 0; all registered outputs take bubble values; illegal 0; stall 0 in the following cycle. A reset mid-multiply abandons it; the multiplier shares rst.
- Latency: instruction accepted in cycle t drives its control bundle in t+1.
- SignaltoMULTU high exactly in cycle t+1 for MULTU accepted in t. cnt = MULT_CYCLES in t+1, reaches 0 in t+1+MULT_CYCLES.
- A dependent MFHI/MFLO presented from t+1 stalls exactly MULT_CYCLES cycles and is accepted in t+1+MULT_CYCLES.
- stall and flush in the same cycle: stall reported, instruction held, nothing issued.

## Structure
- Shared package alu_pkg: funct constants (AND, OR, ADD, SUB, SLT, SLL, MULTU, JR, MFHI, MFLO), ALUOp codes, operation codes, SignaltoMUX select codes, and the bubble bundle value. The execute cluster uses the same package.
- One sub-module: mult_busy_counter (load, decrement, busy), parameterised by MULT_CYCLES.

## Test plan
- Reset: rst=0 for 2 cycles with in_valid=1, funct 25 -> after reset ex_valid 0, operation 010, MUX 00, MULTU 0, stall 0.
- R-type sweep: ALUOp 10, funct 36/37/32/34/42/0 -> next cycle operation 000/001/010/110/111; for funct 0, SHT 1 and MUX 11.
- Multiply hazard (MULT_CYCLES=4): MULTU accepted in cycle 0, MFHI held from cycle 1 -> MULTU pulse in cycle 1 only, stall cycles 1–4, MFHI issues with MUX 01 in cycle 6.
- Independent issue while busy: MULTU then ADD, OR -> no stall, ADD/OR issue on consecutive cycles.
- Flush: MULTU with flush=1 -> bubble, cnt stays 0. A following MFLO is accepted immediately with MUX 10.
- Illegal: ALUOp 10, funct 63 -> illegal pulse 1 cycle, bubble bundle. Mid-multiply reset -> cnt 0, pending MFHI accepted the first cycle after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU-control/issue stage and the execute-stage ALU cluster:
// ALUOp codes, R-type funct values, ALU operations, result-mux selects and the bubble bundle.
package alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_e;

  typedef enum logic [5:0] {
    FUNCT_SLL   = 6'd0,
    FUNCT_JR    = 6'd8,
    FUNCT_MFHI  = 6'd16,
    FUNCT_MFLO  = 6'd18,
    FUNCT_MULTU = 6'd25,
    FUNCT_ADD   = 6'd32,
    FUNCT_SUB   = 6'd34,
    FUNCT_AND   = 6'd36,
    FUNCT_OR    = 6'd37,
    FUNCT_SLT   = 6'd42
  } funct_e;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    MUX_ALU = 2'b00,
    MUX_HI  = 2'b01,
    MUX_LO  = 2'b10,
    MUX_SHT = 2'b11
  } mux_sel_e;

  // Control bundle handed to the execute cluster each cycle.
  typedef struct packed {
    logic     ex_valid;
    alu_op_e  operation;
    logic     multu;
    logic     sht;
    mux_sel_e mux;
    logic     jr;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    ex_valid:  1'b0,
    operation: OP_ADD,
    multu:     1'b0,
    sht:       1'b0,
    mux:       MUX_ALU,
    jr:        1'b0
  };

  // Instructions that read or write Hi/Lo and therefore must wait for the multiplier.
  function automatic logic is_hilo_op(input logic [1:0] aluop, input logic [5:0] funct);
    return (aluop == ALUOP_RTYPE) &&
           ((funct == FUNCT_MULTU) || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO));
  endfunction

endpackage

// File: rtl/mult_busy_counter.sv
// Tracks the in-flight MULTU: loads MULT_CYCLES on issue and counts down to idle.
module mult_busy_counter #(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_busy_c
);

  localparam int unsigned CNT_W = $clog2(MULT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy_c = (r_cnt != '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU-control/issue stage: decodes ALUOp/funct into the execute control bundle one cycle
// later and holds Hi/Lo consumers until the outstanding multiply has finished.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  input  logic       flush,
  output logic       stall,
  output logic       ex_valid,
  output logic [2:0] operation,
  output logic       SignaltoMULTU,
  output logic       SignaltoSHT,
  output logic [1:0] SignaltoMUX,
  output logic       jr,
  output logic       illegal
);

  logic  w_busy;
  logic  w_is_hilo;
  logic  w_accept;
  logic  w_legal;
  logic  w_is_multu;
  ctrl_t w_dec;
  ctrl_t r_ctrl;
  logic  r_illegal;

  assign w_is_hilo  = is_hilo_op(ALUOp, funct);
  assign stall      = in_valid & w_busy & w_is_hilo;
  assign w_accept   = in_valid & ~stall & ~flush;
  assign w_is_multu = (ALUOp == ALUOP_RTYPE) && (funct == FUNCT_MULTU);

  // Decode of the presented instruction, independent of whether it is accepted.
  always_comb begin
    w_dec          = CTRL_BUBBLE;
    w_dec.ex_valid = 1'b1;
    w_legal        = 1'b1;
    case (aluop_e'(ALUOp))
      ALUOP_ADD: w_dec.operation = OP_ADD;
      ALUOP_SUB: w_dec.operation = OP_SUB;
      ALUOP_SLT: w_dec.operation = OP_SLT;
      default: begin
        case (funct)
          FUNCT_AND: w_dec.operation = OP_AND;
          FUNCT_OR:  w_dec.operation = OP_OR;
          FUNCT_ADD: w_dec.operation = OP_ADD;
          FUNCT_SUB: w_dec.operation = OP_SUB;
          FUNCT_SLT: w_dec.operation = OP_SLT;
          FUNCT_SLL: begin
            w_dec.sht = 1'b1;
            w_dec.mux = MUX_SHT;
          end
          FUNCT_MULTU: w_dec.multu = 1'b1;
          FUNCT_MFHI:  w_dec.mux   = MUX_HI;
          FUNCT_MFLO:  w_dec.mux   = MUX_LO;
          FUNCT_JR: begin
            w_dec.jr        = 1'b1;
            w_dec.operation = OP_ADD;
          end
          default: w_legal = 1'b0;
        endcase
      end
    endcase
  end

  // Control half of the ID/EX register; anything not accepted becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= (w_accept && w_legal) ? w_dec : CTRL_BUBBLE;
      r_illegal <= w_accept & ~w_legal;
    end
  end

  mult_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept & w_is_multu),
    .o_busy_c (w_busy)
  );

  assign ex_valid      = r_ctrl.ex_valid;
  assign operation     = r_ctrl.operation;
  assign SignaltoMULTU = r_ctrl.multu;
  assign SignaltoSHT   = r_ctrl.sht;
  assign SignaltoMUX   = r_ctrl.mux;
  assign jr            = r_ctrl.jr;
  assign illegal       = r_illegal;

endmodule
